// File: rtl/mem_word_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_arb
// Description : Round-robin arbiter and beat sequencer sharing one byte-wide
//               memory port between a read/write word requester (port 0) and
//               a read-only word requester (port 1). Words are moved as four
//               big-endian byte beats.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef CPU_BYTE
`define CPU_BYTE 8
`endif

module mem_word_arb #(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [ADDR_W-1:0]      p0_addr,
    input  logic [`CPU_WIDTH-1:0]  p0_wdata,
    output logic                   p0_done,
    output logic                   p0_err,
    output logic [`CPU_WIDTH-1:0]  p0_rdata,
    input  logic                   p1_req,
    input  logic [ADDR_W-1:0]      p1_addr,
    output logic                   p1_done,
    output logic                   p1_err,
    output logic [`CPU_WIDTH-1:0]  p1_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [`CPU_BYTE-1:0]   mem_wdata,
    input  logic [`CPU_BYTE-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BEAT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_owner;
    logic                    r_last_owner;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_we;
    logic [`CPU_WIDTH-1:0]   r_wdata;
    logic [1:0]              r_beat;
    logic                    r_err;
    logic [`CPU_WIDTH-1:0]   r_acc;
    logic                    r_rd_pend;

    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_gnt;
    logic                    w_gnt_port;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic                    w_misaligned;
    logic [`CPU_WIDTH-1:0]   w_wshift;

    // On a tie the port that did not own the previous access wins.
    assign w_gnt0       = p0_req && (!p1_req || r_last_owner);
    assign w_gnt1       = p1_req && (!p0_req || !r_last_owner);
    assign w_gnt        = w_gnt0 || w_gnt1;
    assign w_gnt_port   = w_gnt1;
    assign w_sel_addr   = w_gnt1 ? p1_addr : p0_addr;
    assign w_misaligned = (w_sel_addr[1:0] != 2'b00);
    // Beat k takes the k-th most significant byte of the latched write word.
    assign w_wshift     = r_wdata << {r_beat, 3'b000};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and all port outputs, decoded from registered state.
    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        p0_done   = 1'b0;
        p0_err    = 1'b0;
        p0_rdata  = '0;
        p1_done   = 1'b0;
        p1_err    = 1'b0;
        p1_rdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt) begin
                    w_next = w_misaligned ? S_DONE : S_BEAT;
                end
            end
            S_BEAT: begin
                mem_en   = 1'b1;
                mem_we   = r_we;
                mem_addr = r_addr + ADDR_W'(r_beat);
                if (r_we) begin
                    mem_wdata = w_wshift[`CPU_WIDTH-1 -: `CPU_BYTE];
                end
                if (r_beat == 2'd3) begin
                    w_next = r_we ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (r_owner) begin
                    p1_done  = 1'b1;
                    p1_err   = r_err;
                    p1_rdata = r_acc;
                end else begin
                    p0_done  = 1'b1;
                    p0_err   = r_err;
                    p0_rdata = r_acc;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latching at grant, beat counting and read-byte accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_beat       <= 2'd0;
            r_err        <= 1'b0;
            r_acc        <= '0;
            r_rd_pend    <= 1'b0;
        end else begin
            // Read data for a beat arrives one cycle after its issue.
            r_rd_pend <= (r_state == S_BEAT) && !r_we;
            if (r_rd_pend) begin
                r_acc <= {r_acc[`CPU_WIDTH-`CPU_BYTE-1:0], mem_rdata};
            end
            if (r_state == S_IDLE && w_gnt) begin
                r_owner      <= w_gnt_port;
                r_last_owner <= w_gnt_port;
                r_addr       <= w_sel_addr;
                r_we         <= w_gnt_port ? 1'b0 : p0_we;
                r_wdata      <= w_gnt_port ? '0 : p0_wdata;
                r_beat       <= 2'd0;
                r_err        <= w_misaligned;
                r_acc        <= '0;
            end else if (r_state == S_BEAT) begin
                r_beat <= r_beat + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire
